tile_addr_gen: RTL and testbench
================================

# tile_addr_gen

Registered DMA address generator for tiled frame access. For each request it converts a tile descriptor (start row/column, size, halo) and a frame descriptor (base address, row stride, pixel size) into a byte base address and transfer length. For reference fetches the region grows by the halo on every side; motion fetches use the bare tile. It sits between the tile scheduler and the DMA read engine.

## Interface
Parameters: none. All widths are fixed.

Ports:
- clk  in  1  system clock, rising edge active
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- req_valid  in  1  request strobe; the descriptor is sampled on a rising edge while high
- is_reference  in  1  1 = reference region (halo applied), 0 = motion region (no halo)
- frame_base_addr  in  32  byte address of frame pixel (0,0)
- frame_stride_bytes  in  16  bytes per frame row
- bytes_per_pixel  in  16  bytes per pixel
- tile_row_start  in  16  first tile row (unsigned)
- tile_col_start  in  16  first tile column (unsigned)
- tile_rows  in  16  tile height in rows
- tile_cols  in  16  tile width in columns
- halo  in  16  halo width in pixels; used only when is_reference=1
- out_valid  out  1  one-cycle pulse: base_addr/length_bytes updated
- base_addr  out  32  region start byte address
- length_bytes  out  32  region size in bytes
- length_ovf  out  1  exact length did not fit in 32 bits

## Operation
- h = is_reference ? halo : 0.
- row_eff = tile_row_start − h; col_eff = tile_col_start − h. Both are 17-bit signed.
- rows_eff = tile_rows + 2h; cols_eff = tile_cols + 2h. Both are 18-bit unsigned.
- base_addr = frame_base_addr + row_eff·frame_stride_bytes + col_eff·bytes_per_pixel. Products are sign-extended; the sum wraps modulo 2^32.
- length_bytes = rows_eff·cols_eff·bytes_per_pixel, truncated to 32 bits.
- length_ovf = 1 when the exact product is ≥ 2^32.
- Near-edge handling (row_eff or col_eff < 0) is controlled by Configuration.
- No far-edge clamping: the block has no frame width or height input.
- Zero tile_rows, tile_cols or bytes_per_pixel gives length_bytes=0. The block raises no error for this.

## Timing
- Reset (rst_n=0, takes effect immediately): out_valid=0, base_addr=0, length_bytes=0, length_ovf=0.
- Latency is 1 cycle:
  - A request sampled at edge N updates the result registers at that same edge.
  - out_valid is high for the cycle after edge N, then returns to 0.
- Throughput is one request per cycle. Back-to-back requests give consecutive out_valid pulses with the matching results.
- base_addr, length_bytes and length_ovf hold their last value until the next accepted request.
- Input changes while req_valid=0 have no effect.
- Reset asserted mid-operation discards any pending result. out_valid does not pulse for that request.
- The first request after reset release is accepted on the first rising edge with rst_n=1.

## Configuration
- Macro: ADDR_GEN_HALO_CLAMP_EN.
- Defined:
  - A negative row_eff is replaced by 0, and rows_eff is reduced by the clipped amount (h − tile_row_start).
  - Columns are clamped the same way.
  - The region never starts above or left of the frame origin.
- Undefined:
  - No clamping.
  - Negative offsets are applied as signed values, so base_addr can fall below frame_base_addr.
  - rows_eff and cols_eff are unchanged.
- Results are identical either way when tile_row_start ≥ h and tile_col_start ≥ h.

## Test plan
Common setup for scenarios 1–3 and 5: frame_base_addr=0x1000_0000, frame_stride_bytes=640, bytes_per_pixel=2, tile_rows=4, tile_cols=8, halo=1.
- Motion fetch: row_start=10, col_start=20, is_reference=0, req_valid for one cycle.
  - Required: out_valid pulse next cycle, base_addr=0x1000_1928, length_bytes=64.
- Reference fetch: same tile with is_reference=1.
  - Required: base_addr=0x1000_16A6, length_bytes=120.
- Near edge: row_start=0, col_start=0, is_reference=1.
  - With the macro defined: base_addr=0x1000_0000, length_bytes=90.
  - With the macro undefined: base_addr=0x0FFF_FD7E, length_bytes=120.
- Overflow: tile_rows=tile_cols=0xFFFF, bytes_per_pixel=0xFFFF, halo=0.
  - Required: length_ovf=1, and length_bytes equals the low 32 bits of the exact product.
- Back-to-back and reset:
  - Motion request then reference request on consecutive cycles → two consecutive out_valid pulses carrying 64 and then 120.
  - Then assert rst_n=0 in the cycle a third request is sampled → all outputs 0 immediately and no out_valid pulse.

Source files
------------

// File: rtl/tile_addr_gen.sv
// Tile DMA address generator: descriptor -> byte base address and length; optional near-edge clamp via ADDR_GEN_HALO_CLAMP_EN.
// Latency 1 cycle (out_valid pulses the cycle after the sampling edge); no backpressure, accepts one request every cycle.
module tile_addr_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        is_reference,
    input  logic [31:0] frame_base_addr,
    input  logic [15:0] frame_stride_bytes,
    input  logic [15:0] bytes_per_pixel,
    input  logic [15:0] tile_row_start,
    input  logic [15:0] tile_col_start,
    input  logic [15:0] tile_rows,
    input  logic [15:0] tile_cols,
    input  logic [15:0] halo,
    output logic        out_valid,
    output logic [31:0] base_addr,
    output logic [31:0] length_bytes,
    output logic        length_ovf
);

    logic [15:0]        h;
    logic signed [16:0] row_raw;
    logic signed [16:0] col_raw;
    logic [17:0]        rows_raw;
    logic [17:0]        cols_raw;
    logic signed [16:0] row_eff;
    logic signed [16:0] col_eff;
    logic [17:0]        rows_eff;
    logic [17:0]        cols_eff;
    logic [31:0]        row_ext;
    logic [31:0]        col_ext;
    logic [31:0]        row_off;
    logic [31:0]        col_off;
    logic [35:0]        area;
    logic [51:0]        len_full;

    logic        out_valid_q, out_valid_d;
    logic [31:0] base_addr_q, base_addr_d;
    logic [31:0] length_q, length_d;
    logic        ovf_q, ovf_d;

    assign h        = is_reference ? halo : 16'd0;
    assign row_raw  = $signed({1'b0, tile_row_start}) - $signed({1'b0, h});
    assign col_raw  = $signed({1'b0, tile_col_start}) - $signed({1'b0, h});
    assign rows_raw = {2'b00, tile_rows} + {1'b0, h, 1'b0};
    assign cols_raw = {2'b00, tile_cols} + {1'b0, h, 1'b0};

`ifdef ADDR_GEN_HALO_CLAMP_EN
    logic [15:0] row_clip;
    logic [15:0] col_clip;

    // Only meaningful when the raw offset is negative, where h > start.
    assign row_clip = h - tile_row_start;
    assign col_clip = h - tile_col_start;

    always_comb begin
        row_eff  = row_raw;
        rows_eff = rows_raw;
        col_eff  = col_raw;
        cols_eff = cols_raw;
        if (row_raw[16]) begin
            row_eff  = 17'sd0;
            rows_eff = rows_raw - {2'b00, row_clip};
        end
        if (col_raw[16]) begin
            col_eff  = 17'sd0;
            cols_eff = cols_raw - {2'b00, col_clip};
        end
    end
`else
    assign row_eff  = row_raw;
    assign col_eff  = col_raw;
    assign rows_eff = rows_raw;
    assign cols_eff = cols_raw;
`endif

    // Modulo-2^32 unsigned multiply of the sign-extended offset gives the signed product's low bits.
    assign row_ext  = {{15{row_eff[16]}}, row_eff};
    assign col_ext  = {{15{col_eff[16]}}, col_eff};
    assign row_off  = row_ext * {16'd0, frame_stride_bytes};
    assign col_off  = col_ext * {16'd0, bytes_per_pixel};

    assign area     = {18'd0, rows_eff} * {18'd0, cols_eff};
    assign len_full = {16'd0, area} * {36'd0, bytes_per_pixel};

    always_comb begin
        out_valid_d = req_valid;
        base_addr_d = base_addr_q;
        length_d    = length_q;
        ovf_d       = ovf_q;
        if (req_valid) begin
            base_addr_d = frame_base_addr + row_off + col_off;
            length_d    = len_full[31:0];
            ovf_d       = |len_full[51:32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            base_addr_q <= 32'd0;
            length_q    <= 32'd0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            base_addr_q <= base_addr_d;
            length_q    <= length_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign base_addr    = base_addr_q;
    assign length_bytes = length_q;
    assign length_ovf   = ovf_q;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Self-checking bench for tile_addr_gen: directed plan cases, back-to-back/reset, then randomized traffic vs. an arithmetic model.
module tb_tile_addr_gen;

    typedef struct {
        bit          isref;
        logic [31:0] fb;
        logic [15:0] stride;
        logic [15:0] bpp;
        logic [15:0] rs;
        logic [15:0] cs;
        logic [15:0] tr;
        logic [15:0] tc;
        logic [15:0] halo;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        is_reference = 1'b0;
    logic [31:0] frame_base_addr = '0;
    logic [15:0] frame_stride_bytes = '0;
    logic [15:0] bytes_per_pixel = '0;
    logic [15:0] tile_row_start = '0;
    logic [15:0] tile_col_start = '0;
    logic [15:0] tile_rows = '0;
    logic [15:0] tile_cols = '0;
    logic [15:0] halo = '0;
    logic        out_valid;
    logic [31:0] base_addr;
    logic [31:0] length_bytes;
    logic        length_ovf;

    int n_chk = 0;
    int n_fail = 0;

    logic        exp_vld = 1'b0;
    logic [31:0] exp_b = '0;
    logic [31:0] exp_l = '0;
    logic        exp_o = 1'b0;

    tile_addr_gen dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .is_reference       (is_reference),
        .frame_base_addr    (frame_base_addr),
        .frame_stride_bytes (frame_stride_bytes),
        .bytes_per_pixel    (bytes_per_pixel),
        .tile_row_start     (tile_row_start),
        .tile_col_start     (tile_col_start),
        .tile_rows          (tile_rows),
        .tile_cols          (tile_cols),
        .halo               (halo),
        .out_valid          (out_valid),
        .base_addr          (base_addr),
        .length_bytes       (length_bytes),
        .length_ovf         (length_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain signed integer arithmetic on the descriptor.
    task automatic model(input desc_t d, output logic [31:0] b, output logic [31:0] l, output logic o);
        longint hh, re, ce, rows, cols, addr, prod;
        hh   = d.isref ? longint'(d.halo) : 0;
        re   = longint'(d.rs) - hh;
        ce   = longint'(d.cs) - hh;
        rows = longint'(d.tr) + 2 * hh;
        cols = longint'(d.tc) + 2 * hh;
`ifdef ADDR_GEN_HALO_CLAMP_EN
        if (re < 0) begin rows = rows + re; re = 0; end
        if (ce < 0) begin cols = cols + ce; ce = 0; end
`endif
        addr = longint'(d.fb) + re * longint'(d.stride) + ce * longint'(d.bpp);
        prod = rows * cols * longint'(d.bpp);
        b = addr[31:0];
        l = prod[31:0];
        o = (prod >= 64'sh1_0000_0000);
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_vld"}, 64'(out_valid), 64'(exp_vld));
        chk({tag, "_base"}, 64'(base_addr), 64'(exp_b));
        chk({tag, "_len"}, 64'(length_bytes), 64'(exp_l));
        chk({tag, "_ovf"}, 64'(length_ovf), 64'(exp_o));
    endtask

    // At each falling edge: check what the previous rising edge produced, then drive the next cycle.
    task automatic step(input desc_t d, input bit v, input string tag);
        @(negedge clk);
        check_outputs(tag);
        req_valid          = v;
        is_reference       = d.isref;
        frame_base_addr    = d.fb;
        frame_stride_bytes = d.stride;
        bytes_per_pixel    = d.bpp;
        tile_row_start     = d.rs;
        tile_col_start     = d.cs;
        tile_rows          = d.tr;
        tile_cols          = d.tc;
        halo               = d.halo;
        if (v) model(d, exp_b, exp_l, exp_o);
        exp_vld = v;
    endtask

    function automatic desc_t rand_desc();
        desc_t d;
        d.isref = 1'($urandom_range(0, 1));
        d.fb    = $urandom;
        if ($urandom_range(0, 3) == 0) begin
            d.stride = 16'($urandom);
            d.bpp    = 16'($urandom);
            d.rs     = 16'($urandom);
            d.cs     = 16'($urandom);
            d.tr     = 16'($urandom);
            d.tc     = 16'($urandom);
            d.halo   = 16'($urandom);
        end else begin
            d.stride = 16'($urandom_range(0, 4096));
            d.bpp    = 16'($urandom_range(0, 8));
            d.rs     = 16'($urandom_range(0, 12));
            d.cs     = 16'($urandom_range(0, 12));
            d.tr     = 16'($urandom_range(0, 16));
            d.tc     = 16'($urandom_range(0, 16));
            d.halo   = 16'($urandom_range(0, 8));
        end
        return d;
    endfunction

    initial begin
        desc_t mot, refd, edge_d, ovf_d, idle, rd;

        mot = '{isref: 1'b0, fb: 32'h1000_0000, stride: 16'd640, bpp: 16'd2,
                rs: 16'd10, cs: 16'd20, tr: 16'd4, tc: 16'd8, halo: 16'd1};
        refd = mot;
        refd.isref = 1'b1;
        edge_d = refd;
        edge_d.rs = 16'd0;
        edge_d.cs = 16'd0;
        ovf_d = mot;
        ovf_d.tr = 16'hFFFF;
        ovf_d.tc = 16'hFFFF;
        ovf_d.bpp = 16'hFFFF;
        ovf_d.halo = 16'd0;
        idle = rand_desc();

        #1 rst_n = 1'b0;
        step(idle, 1'b0, "reset");
        step(idle, 1'b0, "reset_hold");
        rst_n = 1'b1;

        step(mot, 1'b1, "pre_motion");
        step(rand_desc(), 1'b0, "motion");
        chk("motion_base_const", 64'(base_addr), 64'h1000_1928);
        chk("motion_len_const", 64'(length_bytes), 64'd64);

        step(refd, 1'b1, "idle_hold");
        step(rand_desc(), 1'b0, "reference");
        chk("ref_base_const", 64'(base_addr), 64'h1000_16A6);
        chk("ref_len_const", 64'(length_bytes), 64'd120);

        step(edge_d, 1'b1, "idle_hold2");
        step(rand_desc(), 1'b0, "near_edge");
`ifdef ADDR_GEN_HALO_CLAMP_EN
        chk("edge_base_const", 64'(base_addr), 64'h1000_0000);
        chk("edge_len_const", 64'(length_bytes), 64'd90);
`else
        chk("edge_base_const", 64'(base_addr), 64'h0FFF_FD7E);
        chk("edge_len_const", 64'(length_bytes), 64'd120);
`endif

        step(ovf_d, 1'b1, "idle_hold3");
        step(idle, 1'b0, "overflow");
        chk("ovf_flag_const", 64'(length_ovf), 64'd1);
        chk("ovf_len_const", 64'(length_bytes), 64'h0002_FFFF);

        // Back-to-back pair, then reset lands on the edge sampling a third request.
        step(mot, 1'b1, "idle_hold4");
        step(refd, 1'b1, "b2b_first");
        chk("b2b_first_len", 64'(length_bytes), 64'd64);
        step(edge_d, 1'b1, "b2b_second");
        chk("b2b_second_len", 64'(length_bytes), 64'd120);
        #2 rst_n = 1'b0;
        #1;
        exp_vld = 1'b0;
        exp_b   = '0;
        exp_l   = '0;
        exp_o   = 1'b0;
        check_outputs("async_rst");
        step(mot, 1'b1, "rst_no_pulse");
        rst_n = 1'b1;
        step(idle, 1'b0, "first_after_rst");

        for (int i = 0; i < 400; i++) begin
            rd = rand_desc();
            step(rd, ($urandom_range(0, 3) != 0), "rand");
        end
        step(idle, 1'b0, "rand_tail");
        step(idle, 1'b0, "final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
